// File: rtl/cdns_str_stream_pkg.sv
// Shared types for the streaming string-join block.
// Holds the FSM state enum, the output beat bundle and the delimiter index width helper.
package cdns_str_stream_pkg;

    localparam int STR_W = 8;

    typedef enum logic {
        S_FIELD = 1'b0,
        S_DELIM = 1'b1
    } state_e;

    // One character beat as held in the output register.
    // Delimiter beats carry eof=0 so they can never look like a list end.
    typedef struct packed {
        logic [STR_W-1:0] data;
        logic             empty;
        logic             eof;
        logic             eol;
    } str_beat_t;

    function automatic int DEL_IDX_W(input int max_del);
        return (max_del < 1) ? 1 : $clog2(max_del + 1);
    endfunction

endpackage

// File: rtl/cdns_str_obuf.sv
// Single-entry registered output stage with valid/ready handshake.
// Ports: push_i/beat_i load a beat when can_load_o; out_valid/out_ready/beat_o drive the sink.
module cdns_str_obuf
    import cdns_str_stream_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  str_beat_t beat_i,
    output logic      can_load_o,
    output logic      out_valid,
    input  logic      out_ready,
    output str_beat_t beat_o
);

    logic      valid_q, valid_d;
    str_beat_t beat_q, beat_d;

    // The slot is free when empty or being drained this cycle.
    assign can_load_o = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        beat_d  = beat_q;
        if (can_load_o) begin
            valid_d = push_i;
            if (push_i) begin
                beat_d = beat_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    assign out_valid = valid_q;
    assign beat_o    = beat_q;

endmodule

// File: rtl/cdns_str_join_stream.sv
// Joins a list of character fields into one stream with a programmable delimiter between fields.
// Ports: del_i/del_len_i delimiter, in_* field beats, out_* joined beats, done_o/fields_o/chars_o list stats.
module cdns_str_join_stream
    import cdns_str_stream_pkg::*;
#(
    parameter int WIDTH   = STR_W,
    parameter int MAX_DEL = 4,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [MAX_DEL*WIDTH-1:0]     del_i,
    input  logic [$clog2(MAX_DEL+1)-1:0] del_len_i,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_empty,
    input  logic                         in_eof,
    input  logic                         in_eol,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_empty,
    output logic                         out_last,
    output logic                         done_o,
    output logic [CNT_W-1:0]             fields_o,
    output logic [CNT_W-1:0]             chars_o
);

    localparam int LW = DEL_IDX_W(MAX_DEL);

    state_e                   state_q, state_d;
    logic [LW-1:0]            idx_q, idx_d;
    logic [LW-1:0]            len_q, len_d;
    logic [MAX_DEL*WIDTH-1:0] del_q, del_d;
    logic                     first_q, first_d;
    logic [CNT_W-1:0]         fields_q, fields_d;
    logic [CNT_W-1:0]         chars_q, chars_d;
    logic [CNT_W-1:0]         fo_q, fo_d;
    logic [CNT_W-1:0]         co_q, co_d;
    logic                     done_q, done_d;

    logic      can_load, push, acc, eof_eff, fire, last_fire;
    logic [LW-1:0] cur_len;
    str_beat_t beat, beat_o;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    cdns_str_obuf u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .beat_i    (beat),
        .can_load_o(can_load),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .beat_o    (beat_o)
    );

    assign in_ready  = (state_q == S_FIELD) && can_load;
    assign acc       = in_valid && in_ready;
    // An empty beat always closes its field, even if eof was left low.
    assign eof_eff   = in_eof || in_empty;
    // The first beat of a list sees the live delimiter, later beats the latched one.
    assign cur_len   = first_q ? del_len_i : len_q;
    assign fire      = out_valid && out_ready;
    assign last_fire = fire && out_last;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        del_d    = del_q;
        first_d  = first_q;
        fields_d = fields_q;
        chars_d  = chars_q;
        fo_d     = fo_q;
        co_d     = co_q;
        done_d   = last_fire;
        push     = 1'b0;
        beat     = '0;
        unique case (state_q)
            S_FIELD: begin
                if (acc) begin
                    if (first_q) begin
                        del_d = del_i;
                        len_d = del_len_i;
                    end
                    if (!in_empty) begin
                        push      = 1'b1;
                        beat.data = in_data;
                        beat.eof  = in_eof;
                        beat.eol  = in_eol;
                    end else if (in_eol) begin
                        push       = 1'b1;
                        beat.empty = 1'b1;
                        beat.eof   = 1'b1;
                        beat.eol   = 1'b1;
                    end
                    first_d = eof_eff && in_eol;
                    // Fields are tallied at input so empty inner fields,
                    // which never reach the output, still count.
                    if (eof_eff) begin
                        fields_d = sat_inc(fields_q);
                        if (!in_eol && cur_len != '0) begin
                            state_d = S_DELIM;
                            idx_d   = '0;
                        end
                    end
                end
            end
            S_DELIM: begin
                if (can_load) begin
                    push      = 1'b1;
                    beat.data = del_q[int'(idx_q)*WIDTH +: WIDTH];
                    if (idx_q == len_q - 1'b1) begin
                        state_d = S_FIELD;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_FIELD;
        endcase
        if (fire && !out_empty) begin
            chars_d = sat_inc(chars_q);
        end
        if (last_fire) begin
            fo_d     = fields_q;
            co_d     = chars_d;
            chars_d  = '0;
            // The next list's first field may close in this very cycle.
            fields_d = (acc && eof_eff) ? CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FIELD;
            idx_q    <= '0;
            len_q    <= '0;
            del_q    <= '0;
            first_q  <= 1'b1;
            fields_q <= '0;
            chars_q  <= '0;
            fo_q     <= '0;
            co_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            del_q    <= del_d;
            first_q  <= first_d;
            fields_q <= fields_d;
            chars_q  <= chars_d;
            fo_q     <= fo_d;
            co_q     <= co_d;
            done_q   <= done_d;
        end
    end

    assign out_data  = beat_o.data;
    assign out_empty = beat_o.empty;
    assign out_last  = beat_o.eof && beat_o.eol;
    assign done_o    = done_q;
    assign fields_o  = fo_q;
    assign chars_o   = co_q;

endmodule

// File: tb/tb_cdns_str_join_stream.sv
// Directed bench for cdns_str_join_stream: table of lists with expected joined output.
// Also covers reset state, backpressure hold, mid-list delimiter change and mid-delimiter reset.
module tb_cdns_str_join_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] del_i = '0;
    logic [2:0]  del_len_i = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_empty = 1'b0;
    logic        in_eof = 1'b0;
    logic        in_eol = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_empty;
    logic        out_last;
    logic        done_o;
    logic [15:0] fields_o;
    logic [15:0] chars_o;

    always #5 clk = ~clk;

    cdns_str_join_stream dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .del_i    (del_i),
        .del_len_i(del_len_i),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_empty (in_empty),
        .in_eof   (in_eof),
        .in_eol   (in_eol),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_empty(out_empty),
        .out_last (out_last),
        .done_o   (done_o),
        .fields_o (fields_o),
        .chars_o  (chars_o)
    );

    typedef struct {
        logic [7:0] d;
        bit         emp;
        bit         eof;
        bit         eol;
    } in_rec_t;

    typedef struct {
        logic [7:0] d;
        bit         emp;
        bit         last;
    } out_rec_t;

    typedef struct {
        logic [31:0] del;
        logic [2:0]  len;
        int          in_base;
        int          n_in;
        int          out_base;
        int          n_out;
        int          fields;
        int          chars;
        bit          rnd;
        bit          chg;
        bit          gapless;
    } case_t;

    in_rec_t  ins[$];
    out_rec_t outs[$];
    case_t    cases[$];
    case_t    cur;
    int       n_chk = 0;
    int       n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void begin_case(input logic [31:0] del, input logic [2:0] len,
                                       input int fields, input int chars,
                                       input bit rnd, input bit chg, input bit gap);
        cur.del      = del;
        cur.len      = len;
        cur.in_base  = ins.size();
        cur.out_base = outs.size();
        cur.fields   = fields;
        cur.chars    = chars;
        cur.rnd      = rnd;
        cur.chg      = chg;
        cur.gapless  = gap;
    endfunction

    function automatic void end_case();
        cur.n_in  = ins.size() - cur.in_base;
        cur.n_out = outs.size() - cur.out_base;
        cases.push_back(cur);
    endfunction

    function automatic void ib(input logic [7:0] d, input bit emp, input bit eof, input bit eol);
        in_rec_t r;
        r.d = d; r.emp = emp; r.eof = eof; r.eol = eol;
        ins.push_back(r);
    endfunction

    function automatic void ob(input logic [7:0] d, input bit emp, input bit last);
        out_rec_t r;
        r.d = d; r.emp = emp; r.last = last;
        outs.push_back(r);
    endfunction

    function automatic void build_tables();
        // c0: "," len 1, "ab","c"
        begin_case(32'h0000002c, 3'd1, 2, 4, 0, 0, 1);
        ib("a", 0, 0, 0); ib("b", 0, 1, 0); ib("c", 0, 1, 1);
        ob("a", 0, 0); ob("b", 0, 0); ob(",", 0, 0); ob("c", 0, 1);
        end_case();
        // c1: ", " len 2, "x","","y"
        begin_case(32'h0000202c, 3'd2, 3, 6, 0, 0, 0);
        ib("x", 0, 1, 0); ib(8'h00, 1, 1, 0); ib("y", 0, 1, 1);
        ob("x", 0, 0); ob(",", 0, 0); ob(" ", 0, 0);
        ob(",", 0, 0); ob(" ", 0, 0); ob("y", 0, 1);
        end_case();
        // c2: single empty last field
        begin_case(32'h0000002c, 3'd1, 1, 0, 0, 0, 0);
        ib(8'h00, 1, 1, 1);
        ob(8'h00, 1, 1);
        end_case();
        // c3: len 0, "ab","cd"
        begin_case(32'h0000002c, 3'd0, 2, 4, 0, 0, 1);
        ib("a", 0, 0, 0); ib("b", 0, 1, 0); ib("c", 0, 0, 0); ib("d", 0, 1, 1);
        ob("a", 0, 0); ob("b", 0, 0); ob("c", 0, 0); ob("d", 0, 1);
        end_case();
        // c4: c0 with random ready and a mid-list delimiter change
        begin_case(32'h0000002c, 3'd1, 2, 4, 1, 1, 0);
        ib("a", 0, 0, 0); ib("b", 0, 1, 0); ib("c", 0, 1, 1);
        ob("a", 0, 0); ob("b", 0, 0); ob(",", 0, 0); ob("c", 0, 1);
        end_case();
        // c5: empty beat without eof closes its field
        begin_case(32'h0000002d, 3'd1, 3, 4, 0, 0, 0);
        ib("a", 0, 1, 0); ib(8'h00, 1, 0, 0); ib("b", 0, 1, 1);
        ob("a", 0, 0); ob("-", 0, 0); ob("-", 0, 0); ob("b", 0, 1);
        end_case();
        // c6: maximum delimiter length "ABCD"
        begin_case(32'h44434241, 3'd4, 2, 6, 0, 0, 1);
        ib("x", 0, 1, 0); ib("y", 0, 1, 1);
        ob("x", 0, 0); ob("A", 0, 0); ob("B", 0, 0);
        ob("C", 0, 0); ob("D", 0, 0); ob("y", 0, 1);
        end_case();
    endfunction

    task automatic run_case(input int c);
        case_t    k;
        out_rec_t e;
        int       ii;
        int       oi;
        int       prev;
        int       last_cyc;
        bit       got;
        bit       hold;
        bit       chg_done;
        logic [9:0] held;
        k = cases[c];
        ii = 0; oi = 0; prev = -1; last_cyc = -10;
        got = 0; hold = 0; chg_done = 0; held = '0;
        del_i = k.del;
        del_len_i = k.len;
        for (int cyc = 0; cyc < 300 && !got; cyc++) begin
            @(negedge clk);
            if (k.chg && ii > 0 && !chg_done) begin
                del_i = 32'h23232323;
                del_len_i = 3'd3;
                chg_done = 1;
            end
            out_ready = k.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ii < k.n_in) begin
                in_valid = 1'b1;
                in_data  = ins[k.in_base+ii].d;
                in_empty = ins[k.in_base+ii].emp;
                in_eof   = ins[k.in_base+ii].eof;
                in_eol   = ins[k.in_base+ii].eol;
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
                in_empty = 1'b0;
                in_eof   = 1'b0;
                in_eol   = 1'b0;
            end
            #1;
            if (hold) begin
                chk($sformatf("c%0d hold", c),
                    32'({out_valid, out_data, out_empty, out_last}), 32'({1'b1, held}));
                hold = 0;
            end
            if (done_o) begin
                chk($sformatf("c%0d fields", c), 32'(fields_o), 32'(k.fields));
                chk($sformatf("c%0d chars", c), 32'(chars_o), 32'(k.chars));
                chk($sformatf("c%0d done lat", c), 32'(cyc - last_cyc), 32'd1);
                got = 1;
            end
            if (out_valid && out_ready) begin
                if (oi < k.n_out) begin
                    e = outs[k.out_base+oi];
                    if (!e.emp) chk($sformatf("c%0d data%0d", c, oi), 32'(out_data), 32'(e.d));
                    chk($sformatf("c%0d empty%0d", c, oi), 32'(out_empty), 32'(e.emp));
                    chk($sformatf("c%0d last%0d", c, oi), 32'(out_last), 32'(e.last));
                    if (k.gapless && oi > 0)
                        chk($sformatf("c%0d gap%0d", c, oi), 32'(cyc - prev), 32'd1);
                end else begin
                    chk($sformatf("c%0d extra beat", c), 32'(oi), 32'(k.n_out));
                end
                if (out_last) last_cyc = cyc;
                prev = cyc;
                oi++;
            end else if (out_valid) begin
                hold = 1;
                held = {out_data, out_empty, out_last};
            end
            if (in_valid && in_ready) ii++;
        end
        in_valid = 1'b0;
        chk($sformatf("c%0d done seen", c), 32'(got), 32'd1);
        chk($sformatf("c%0d beats", c), 32'(oi), 32'(k.n_out));
    endtask

    bit found;

    initial begin
        build_tables();
        repeat (2) @(negedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst out_last", 32'(out_last), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        chk("rst fields", 32'(fields_o), 32'd0);
        chk("rst chars", 32'(chars_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd1);

        for (int c = 0; c < cases.size(); c++) begin
            run_case(c);
        end

        // Reset while the second delimiter character sits in the output register.
        del_i = 32'h003a3b2c;
        del_len_i = 3'd3;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = "a"; in_empty = 1'b0; in_eof = 1'b1; in_eol = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (out_valid && out_data == 8'h3b) found = 1;
        end
        chk("rr reached delim2", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rr out_valid", 32'(out_valid), 32'd0);
        chk("rr out_data", 32'(out_data), 32'd0);
        chk("rr out_empty", 32'(out_empty), 32'd0);
        chk("rr out_last", 32'(out_last), 32'd0);
        chk("rr done", 32'(done_o), 32'd0);
        chk("rr fields", 32'(fields_o), 32'd0);
        chk("rr chars", 32'(chars_o), 32'd0);
        chk("rr in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rr no done", 32'(done_o), 32'd0);
            chk("rr idle", 32'(out_valid), 32'd0);
        end
        run_case(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
